mnist_inference_scheduler: RTL and testbench

Top-level sequencer for the two-layer MNIST datapath: one pass from start to displayed result.
- Clears the neuron accumulators, then streams bias and pixel/weight ROM addresses into the ten layer-1 neurons.
- Streams bias and hidden-neuron addresses into the ten layer-2 neurons.
- Reads the ten digit scores serially, computes the argmax and presents it to the seven-segment decoder with a start/busy/done handshake.
- Replaces the free-running controller plus combinational argmax in the top level.

---
 rtl/mnist_inference_scheduler.sv | 158 +++++++++++++++
 tb/tb_mnist_inference_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_inference_scheduler.sv
// Sequencer for the two-layer MNIST datapath: clears accumulators, streams layer-1 and
// layer-2 ROM addresses with latency-matched strobes, then scans the ten scores for the argmax.
module mnist_inference_scheduler #(
    parameter int N_PIXELS = 784,
    parameter int N_NEURON = 10,
    parameter int MEM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        acc_clr,
    output logic [11:0] pixel_addr,
    output logic [3:0]  bias_addr,
    output logic [10:0] bias_load,
    output logic        valid_pixel,
    output logic [3:0]  layer1_addr,
    output logic [3:0]  layer1_addr_delay,
    output logic        valid_digit,
    output logic [3:0]  digit_sel,
    input  logic [31:0] digit_value,
    output logic [3:0]  result_index
);

    localparam logic [9:0] PIX_LAST = 10'(N_PIXELS - 1);
    localparam logic [3:0] NEU_LAST = 4'(N_NEURON - 1);
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    typedef enum logic [3:0] {
        IDLE, CLR, BIAS1, L1, L1_DRAIN, BIAS2, L2, L2_DRAIN, ARGMAX, DONE
    } state_t;

    state_t state, next_state;

    logic [9:0]         pixel_cnt;
    logic [1:0]         drain_cnt;
    logic signed [31:0] run_max;
    logic [3:0]         best_idx;
    logic               new_max;

    logic [MEM_LAT-1:0] pix_pipe;
    logic [MEM_LAT-1:0] dig_pipe;
    logic [MEM_LAT-1:0] bias_vld_pipe;
    logic [3:0]         bias_addr_pipe [MEM_LAT];
    logic [3:0]         l1_addr_pipe   [MEM_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = CLR;
            CLR:      next_state = BIAS1;
            BIAS1:    if (bias_addr == NEU_LAST) next_state = L1;
            L1:       if (pixel_cnt == PIX_LAST) next_state = L1_DRAIN;
            L1_DRAIN: if (drain_cnt == LAT_LAST) next_state = BIAS2;
            BIAS2:    if (bias_addr == NEU_LAST) next_state = L2;
            L2:       if (layer1_addr == NEU_LAST) next_state = L2_DRAIN;
            L2_DRAIN: if (drain_cnt == LAT_LAST) next_state = ARGMAX;
            ARGMAX:   if (digit_sel == NEU_LAST) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    // Each counter restarts on entry to its own state and otherwise holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_cnt   <= '0;
            drain_cnt   <= '0;
            bias_addr   <= '0;
            layer1_addr <= '0;
            digit_sel   <= '0;
        end else begin
            case (next_state)
                BIAS1, BIAS2:       bias_addr   <= (state == next_state) ? bias_addr + 4'd1 : 4'd0;
                L1:                 pixel_cnt   <= (state == L1) ? pixel_cnt + 10'd1 : 10'd0;
                L1_DRAIN, L2_DRAIN: drain_cnt   <= (state == next_state) ? drain_cnt + 2'd1 : 2'd0;
                L2:                 layer1_addr <= (state == L2) ? layer1_addr + 4'd1 : 4'd0;
                ARGMAX:             digit_sel   <= (state == ARGMAX) ? digit_sel + 4'd1 : 4'd0;
                default: ;
            endcase
        end
    end

    assign new_max = $signed(digit_value) > run_max;

    // Strict compare keeps the lowest index on ties; the last score is folded in on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max      <= '0;
            best_idx     <= '0;
            result_index <= '0;
        end else begin
            if (state == ARGMAX && (digit_sel == 4'd0 || new_max)) begin
                run_max  <= $signed(digit_value);
                best_idx <= digit_sel;
            end
            if (state == ARGMAX && next_state == DONE) begin
                result_index <= new_max ? digit_sel : best_idx;
            end
        end
    end

    // Strobes trail their addresses by MEM_LAT cycles; abort flushes anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_pipe      <= '0;
            dig_pipe      <= '0;
            bias_vld_pipe <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                bias_addr_pipe[i] <= '0;
                l1_addr_pipe[i]   <= '0;
            end
        end else begin
            bias_addr_pipe[0] <= bias_addr;
            l1_addr_pipe[0]   <= layer1_addr;
            for (int i = 1; i < MEM_LAT; i++) begin
                bias_addr_pipe[i] <= bias_addr_pipe[i-1];
                l1_addr_pipe[i]   <= l1_addr_pipe[i-1];
            end
            if (abort) begin
                pix_pipe      <= '0;
                dig_pipe      <= '0;
                bias_vld_pipe <= '0;
            end else begin
                pix_pipe[0]      <= (state == L1);
                dig_pipe[0]      <= (state == L2);
                bias_vld_pipe[0] <= (state == BIAS1) || (state == BIAS2);
                for (int i = 1; i < MEM_LAT; i++) begin
                    pix_pipe[i]      <= pix_pipe[i-1];
                    dig_pipe[i]      <= dig_pipe[i-1];
                    bias_vld_pipe[i] <= bias_vld_pipe[i-1];
                end
            end
        end
    end

    assign busy              = (state != IDLE) && (state != DONE);
    assign done              = (state == DONE);
    assign acc_clr           = (state == CLR);
    assign pixel_addr        = {2'b00, pixel_cnt};
    assign valid_pixel       = pix_pipe[MEM_LAT-1];
    assign valid_digit       = dig_pipe[MEM_LAT-1];
    assign layer1_addr_delay = l1_addr_pipe[MEM_LAT-1];
    assign bias_load         = bias_vld_pipe[MEM_LAT-1]
                             ? (11'd1 << (bias_addr_pipe[MEM_LAT-1] + 4'd1)) : 11'd0;

endmodule

// File: tb/tb_mnist_inference_scheduler.sv
// Bench for mnist_inference_scheduler: MEM_LAT=1 and MEM_LAT=2 instances run side by side
// against a table of score vectors plus abort, reset and held-start sequences.
module tb_mnist_inference_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic        busy_s [2];
    logic        done_s [2];
    logic        acc_clr_s [2];
    logic [11:0] pixel_addr_s [2];
    logic [3:0]  bias_addr_s [2];
    logic [10:0] bias_load_s [2];
    logic        valid_pixel_s [2];
    logic [3:0]  layer1_addr_s [2];
    logic [3:0]  l1d_s [2];
    logic        valid_digit_s [2];
    logic [3:0]  digit_sel_s [2];
    logic [31:0] digit_value_s [2];
    logic [3:0]  result_index_s [2];

    logic [9:0][31:0] cur_scores;

    typedef struct packed {
        logic [9:0][31:0] scores;
        logic [3:0]       exp_idx;
    } vec_t;

    vec_t vecs [5];

    int compared = 0;
    int failed   = 0;

    int acc_clr_cyc [2];
    int busy_cnt [2];
    int done_count [2];
    int done_cyc [2];
    int done_cyc2 [2];
    int first_bias_cyc [2];
    int first_bias_val [2];
    int bias_cnt [2];
    int bias_seq_err [2];
    int overlap [2];
    int vp_first [2];
    int vp_cnt [2];
    int vd_cnt [2];
    int l1d_err [2];

    always #10 clk = ~clk;

    assign digit_value_s[0] = (digit_sel_s[0] < 4'd10) ? cur_scores[digit_sel_s[0]] : 32'd0;
    assign digit_value_s[1] = (digit_sel_s[1] < 4'd10) ? cur_scores[digit_sel_s[1]] : 32'd0;

    mnist_inference_scheduler #(.N_PIXELS(784), .N_NEURON(10), .MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy_s[0]), .done(done_s[0]), .acc_clr(acc_clr_s[0]),
        .pixel_addr(pixel_addr_s[0]), .bias_addr(bias_addr_s[0]), .bias_load(bias_load_s[0]),
        .valid_pixel(valid_pixel_s[0]), .layer1_addr(layer1_addr_s[0]),
        .layer1_addr_delay(l1d_s[0]), .valid_digit(valid_digit_s[0]),
        .digit_sel(digit_sel_s[0]), .digit_value(digit_value_s[0]),
        .result_index(result_index_s[0])
    );

    mnist_inference_scheduler #(.N_PIXELS(784), .N_NEURON(10), .MEM_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy_s[1]), .done(done_s[1]), .acc_clr(acc_clr_s[1]),
        .pixel_addr(pixel_addr_s[1]), .bias_addr(bias_addr_s[1]), .bias_load(bias_load_s[1]),
        .valid_pixel(valid_pixel_s[1]), .layer1_addr(layer1_addr_s[1]),
        .layer1_addr_delay(l1d_s[1]), .valid_digit(valid_digit_s[1]),
        .digit_sel(digit_sel_s[1]), .digit_value(digit_value_s[1]),
        .result_index(result_index_s[1])
    );

    function automatic vec_t mk_vec(input int s0, input int s1, input int s2, input int s3,
                                    input int s4, input int s5, input int s6, input int s7,
                                    input int s8, input int s9, input int e);
        vec_t v;
        v.scores[0] = s0; v.scores[1] = s1; v.scores[2] = s2; v.scores[3] = s3;
        v.scores[4] = s4; v.scores[5] = s5; v.scores[6] = s6; v.scores[7] = s7;
        v.scores[8] = s8; v.scores[9] = s9;
        v.exp_idx = 4'(e);
        return v;
    endfunction

    function automatic logic [47:0] pack_out(input int d);
        return {busy_s[d], done_s[d], acc_clr_s[d], pixel_addr_s[d], bias_addr_s[d],
                bias_load_s[d], valid_pixel_s[d], layer1_addr_s[d], l1d_s[d],
                valid_digit_s[d], digit_sel_s[d], result_index_s[d]};
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic sample_dut(input int d, input int n);
        if (acc_clr_s[d] && acc_clr_cyc[d] < 0) acc_clr_cyc[d] = n;
        if (busy_s[d]) busy_cnt[d]++;
        if (done_s[d]) begin
            done_count[d]++;
            if (done_count[d] == 1) done_cyc[d] = n;
            else if (done_count[d] == 2) done_cyc2[d] = n;
        end
        if (bias_load_s[d] != 11'd0) begin
            if (first_bias_cyc[d] < 0) begin
                first_bias_cyc[d] = n;
                first_bias_val[d] = int'(bias_load_s[d]);
            end
            if (bias_load_s[d] != (11'd1 << ((bias_cnt[d] % 10) + 1))) bias_seq_err[d]++;
            if (valid_pixel_s[d] || valid_digit_s[d]) overlap[d]++;
            bias_cnt[d]++;
        end
        if (valid_pixel_s[d]) begin
            if (vp_first[d] < 0) vp_first[d] = n;
            vp_cnt[d]++;
        end
        if (valid_digit_s[d]) begin
            if (l1d_s[d] != 4'(vd_cnt[d] % 10)) l1d_err[d]++;
            vd_cnt[d]++;
        end
    endtask

    // Cycle n counts from the edge that samples start; n=1 is the first busy cycle.
    task automatic applyStimulus(input int lim, input bit hold_start);
        for (int d = 0; d < 2; d++) begin
            acc_clr_cyc[d] = -1; busy_cnt[d] = 0; done_count[d] = 0;
            done_cyc[d] = -1; done_cyc2[d] = -1; first_bias_cyc[d] = -1;
            first_bias_val[d] = 0; bias_cnt[d] = 0; bias_seq_err[d] = 0;
            overlap[d] = 0; vp_first[d] = -1; vp_cnt[d] = 0; vd_cnt[d] = 0; l1d_err[d] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= lim; n++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            sample_dut(0, n);
            sample_dut(1, n);
            if (!hold_start && done_count[0] >= 1 && done_count[1] >= 1) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int found;
        int extra_done;

        vecs[0] = mk_vec(5, -3, 9, 9, 2, 0, 0, 0, 0, 1, 2);
        vecs[1] = mk_vec(-10, -2, -7, -5, -3, -8, -4, -6, -11, -9, 1);
        vecs[2] = mk_vec(1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 9);
        vecs[3] = mk_vec(2147483647, -1, 2147483647, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk_vec(-2147483647 - 1, -2147483647 - 1, -2147483647 - 1, -2147483647 - 1,
                         -2147483647 - 1, -2147483647 - 1, -2147483647 - 1, -2147483647 - 1,
                         -2147483647 - 1, -2147483647, 9);
        cur_scores = vecs[0].scores;

        #5;
        checkOutput("reset_outputs_lat1", pack_out(0), 0);
        checkOutput("reset_outputs_lat2", pack_out(1), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            cur_scores = vecs[v].scores;
            applyStimulus(1200, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("v%0d_result_lat%0d", v, d + 1), result_index_s[d], vecs[v].exp_idx);
                checkOutput($sformatf("v%0d_done_cycle_lat%0d", v, d + 1), done_cyc[d], 826 + 2 * (d + 1));
                if (v == 0) begin
                    checkOutput($sformatf("busy_cycles_lat%0d", d + 1), busy_cnt[d], 825 + 2 * (d + 1));
                    checkOutput($sformatf("acc_clr_cycle_lat%0d", d + 1), acc_clr_cyc[d], 1);
                    checkOutput($sformatf("first_bias_cycle_lat%0d", d + 1), first_bias_cyc[d], 3 + d);
                    checkOutput($sformatf("first_bias_value_lat%0d", d + 1), first_bias_val[d], 2);
                    checkOutput($sformatf("bias_count_lat%0d", d + 1), bias_cnt[d], 20);
                    checkOutput($sformatf("bias_sequence_lat%0d", d + 1), bias_seq_err[d], 0);
                    checkOutput($sformatf("strobe_overlap_lat%0d", d + 1), overlap[d], 0);
                    checkOutput($sformatf("valid_pixel_first_lat%0d", d + 1), vp_first[d], 13 + d);
                    checkOutput($sformatf("valid_pixel_count_lat%0d", d + 1), vp_cnt[d], 784);
                    checkOutput($sformatf("valid_digit_count_lat%0d", d + 1), vd_cnt[d], 10);
                    checkOutput($sformatf("layer1_addr_delay_lat%0d", d + 1), l1d_err[d], 0);
                end
            end
        end

        // Abort mid layer-1: no done, result held, then a clean rerun.
        cur_scores = vecs[0].scores;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 1000; n++) begin
            if (pixel_addr_s[0] == 12'd400) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("abort_reached_pixel_400", found, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("abort_busy_lat%0d", d + 1), busy_s[d], 0);
            checkOutput($sformatf("abort_valid_pixel_lat%0d", d + 1), valid_pixel_s[d], 0);
            checkOutput($sformatf("abort_bias_load_lat%0d", d + 1), bias_load_s[d], 0);
        end
        extra_done = 0;
        for (int n = 0; n < 900; n++) begin
            @(negedge clk);
            if (done_s[0] || done_s[1] || busy_s[0] || busy_s[1]) extra_done++;
        end
        checkOutput("abort_no_done", extra_done, 0);
        checkOutput("abort_result_kept_lat1", result_index_s[0], 9);
        checkOutput("abort_result_kept_lat2", result_index_s[1], 9);
        applyStimulus(1200, 1'b0);
        checkOutput("after_abort_done_cycle", done_cyc[0], 828);
        checkOutput("after_abort_result", result_index_s[0], 2);

        // Abort together with start in IDLE must not launch a pass.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_idle_busy", busy_s[0], 0);
        checkOutput("abort_start_idle_acc_clr", acc_clr_s[0], 0);

        // Asynchronous reset during layer 2.
        cur_scores = vecs[1].scores;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 810; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("in_layer2_addr", layer1_addr_s[0], 3);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_outputs_lat1", pack_out(0), 0);
        checkOutput("mid_reset_outputs_lat2", pack_out(1), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1200, 1'b0);
        checkOutput("after_reset_done_cycle", done_cyc[0], 828);
        checkOutput("after_reset_busy_cycles", busy_cnt[0], 827);
        checkOutput("after_reset_result", result_index_s[0], 1);

        // Start held high: back-to-back passes, no extra ones from start during busy.
        cur_scores = vecs[0].scores;
        applyStimulus(1700, 1'b1);
        checkOutput("held_first_done_lat1", done_cyc[0], 828);
        checkOutput("held_second_done_lat1", done_cyc2[0], 1657);
        checkOutput("held_done_count_lat1", done_count[0], 2);
        checkOutput("held_first_done_lat2", done_cyc[1], 830);
        checkOutput("held_second_done_lat2", done_cyc2[1], 1661);
        checkOutput("held_done_count_lat2", done_count[1], 2);
        checkOutput("held_result", result_index_s[0], 2);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
